// File: rtl/gray_pkg.sv
// Shared types and the Gray-to-binary helper for the Gray-code receiver.
package gray_pkg;

  localparam int DEF_W          = 8;
  localparam int DEF_LOCK_STEPS = 4;
  localparam int DEF_CNT_W      = 8;
  localparam int MAX_W          = 32;
  localparam int GOOD_W         = 4;

  typedef enum logic {
    SEEK   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2,
    SKIP = 2'd3
  } event_t;

  // Zero-extended input: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b = g;
    for (int i = 1; i < MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Two-flop synchroniser for an asynchronous multi-bit Gray bus.
module gray_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/gray_rx.sv
// Gray-code bus receiver: synchronises, decodes to binary, checks for single
// forward steps, tracks lock and counts errors seen while locked.
module gray_rx
  import gray_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int LOCK_STEPS = DEF_LOCK_STEPS,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     gray_in,
  input  logic             clr_err,
  output logic [W-1:0]     bin_out,
  output logic             step,
  output logic             locked,
  output logic [CNT_W-1:0] err_cnt
);

  logic [W-1:0]      s2;
  logic [W-1:0]      g_q;
  logic [W-1:0]      b_now;
  logic [W-1:0]      delta;
  logic [GOOD_W-1:0] good_cnt;
  state_t            state;
  event_t            evt;

  gray_sync #(.W(W)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (gray_in),
    .q     (s2)
  );

  assign b_now = W'(gray2bin(MAX_W'(s2)));
  // bin_out always holds gray2bin(g_q), so it doubles as the reference binary.
  assign delta = b_now - bin_out;

  always_comb begin
    evt = SKIP;
    if (s2 == g_q)
      evt = IDLE;
    else if (delta == W'(1))
      evt = FWD;
    else if (delta == {W{1'b1}})
      evt = REV;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_q      <= '0;
      bin_out  <= '0;
      step     <= 1'b0;
      locked   <= 1'b0;
      err_cnt  <= '0;
      good_cnt <= '0;
      state    <= SEEK;
    end else begin
      step <= (evt == FWD);
      if (evt != IDLE) begin
        g_q     <= s2;
        bin_out <= b_now;
      end
      case (state)
        SEEK: begin
          if (evt == FWD) begin
            if (good_cnt == GOOD_W'(LOCK_STEPS - 1)) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              good_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + GOOD_W'(1);
            end
          end else if (evt == REV || evt == SKIP) begin
            good_cnt <= '0;
          end
        end
        LOCKED: begin
          if (evt == REV || evt == SKIP) begin
            state    <= SEEK;
            locked   <= 1'b0;
            good_cnt <= '0;
            if (err_cnt != {CNT_W{1'b1}})
              err_cnt <= err_cnt + CNT_W'(1);
          end
        end
        default: state <= SEEK;
      endcase
      // Clear wins over a simultaneous increment.
      if (clr_err)
        err_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_gray_rx.sv
// Self-checking bench for gray_rx: directed scenarios plus random stepping
// against a binary-level reference model.
module tb_gray_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] gray_in = 8'd0;
  logic       clr_err = 1'b0;
  logic [7:0] bin_out;
  logic       step;
  logic       locked;
  logic [7:0] err_cnt;

  int gtab [256];
  int n_chk  = 0;
  int n_pass = 0;
  int n_txn  = 0;

  int m_b    = 0;
  int m_lock = 0;
  int m_cnt  = 0;
  int m_err  = 0;

  gray_rx #(.W(8), .LOCK_STEPS(4), .CNT_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .gray_in (gray_in),
    .clr_err (clr_err),
    .bin_out (bin_out),
    .step    (step),
    .locked  (locked),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_b = 0; m_lock = 0; m_cnt = 0; m_err = 0;
  endtask

  // Drive the Gray code of binary value nb, hold it 4 clocks, check outputs.
  task automatic apply(input int nb, input bit clr);
    string kind;
    int    exp_step;
    gray_in = 8'(gtab[nb]);
    @(posedge clk);
    @(posedge clk);
    #1 clr_err = clr;
    @(posedge clk);
    #1 clr_err = 1'b0;
    exp_step = 0;
    if (nb == m_b) begin
      kind = "idle";
    end else if (nb == ((m_b + 1) % 256)) begin
      kind = "fwd";
      exp_step = 1;
      if (!m_lock) begin
        m_cnt++;
        if (m_cnt == 4) begin
          m_lock = 1;
          m_cnt  = 0;
        end
      end
    end else begin
      kind = (nb == ((m_b + 255) % 256)) ? "rev" : "skip";
      if (m_lock) begin
        if (m_err < 255) m_err++;
        m_lock = 0;
      end
      m_cnt = 0;
    end
    if (clr) m_err = 0;
    m_b = nb;
    chk("bin_out", 32'(bin_out), 32'(m_b));
    chk("step_pulse", 32'(step), 32'(exp_step));
    chk("locked", 32'(locked), 32'(m_lock));
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
    @(posedge clk);
    #1;
    chk("step_low", 32'(step), 32'd0);
    chk("locked_hold", 32'(locked), 32'(m_lock));
    n_txn++;
    $display("txn %0d %s bin=%0d clr=%0b step=%0b locked=%0b err=%0d",
             n_txn, kind, bin_out, clr, exp_step, locked, err_cnt);
  endtask

  initial begin
    int b;
    for (int i = 0; i < 256; i++) gtab[i] = i ^ (i >> 1);

    // Reset state, then hold gray_in at 0.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bin", 32'(bin_out), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    reset = 1'b0;
    model_reset();
    repeat (2) apply(0, 1'b0);

    // Binary 1..4 should bring lock.
    for (int v = 1; v <= 4; v++) apply(v, 1'b0);
    chk("lock_after_4", 32'(locked), 32'd1);

    // Gray 5 (binary 6) from binary 4: skip while locked.
    apply(6, 1'b0);
    chk("skip_err", 32'(err_cnt), 32'd1);
    for (int v = 7; v <= 10; v++) apply(v, 1'b0);
    chk("relock", 32'(locked), 32'd1);

    // Wrap 254 -> 255 -> 0 while locked.
    apply(250, 1'b0);
    for (int v = 251; v <= 254; v++) apply(v, 1'b0);
    apply(255, 1'b0);
    apply(0, 1'b0);
    chk("wrap_locked", 32'(locked), 32'd1);
    chk("wrap_bin", 32'(bin_out), 32'd0);

    // Reverse step while locked at binary 3.
    apply(200, 1'b0);
    apply(255, 1'b0);
    for (int v = 0; v <= 3; v++) apply(v, 1'b0);
    apply(2, 1'b0);
    chk("rev_unlock", 32'(locked), 32'd0);

    // Drive err_cnt to saturation and one beyond.
    while (m_err < 255 || m_lock == 0) begin
      b = m_b;
      if (m_err == 255) begin
        for (int k = 1; k <= 4; k++) apply((b + k) % 256, 1'b0);
      end else begin
        for (int k = 1; k <= 4; k++) apply((b + k) % 256, 1'b0);
        apply((b + 100) % 256, 1'b0);
      end
    end
    apply((m_b + 77) % 256, 1'b0);
    chk("err_sat", 32'(err_cnt), 32'd255);

    // Clear coinciding with an error.
    b = m_b;
    for (int k = 1; k <= 4; k++) apply((b + k) % 256, 1'b0);
    apply((m_b + 50) % 256, 1'b1);
    chk("clr_prio", 32'(err_cnt), 32'd0);

    // Random stepping.
    for (int t = 0; t < 200; t++) begin
      int r;
      int nb;
      r = int'($urandom_range(0, 9));
      if (r < 6)       nb = (m_b + 1) % 256;
      else if (r == 6) nb = m_b;
      else if (r == 7) nb = (m_b + 255) % 256;
      else             nb = int'($urandom_range(0, 255));
      apply(nb, ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset while locked at 100.
    apply(96, 1'b0);
    for (int v = 97; v <= 100; v++) apply(v, 1'b0);
    chk("pre_rst_lock", 32'(locked), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("arst_bin", 32'(bin_out), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_err", 32'(err_cnt), 32'd0);
    chk("arst_step", 32'(step), 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    apply(101, 1'b0);
    chk("post_rst_bin", 32'(bin_out), 32'd101);
    chk("post_rst_err", 32'(err_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
